instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Initiator side of the instruction-memory interface. Holds the PC and drives imem_addr.
//  Captures the instruction word, which memory returns combinationally in the same cycle.
//  Buffers {pc, instr} pairs in a small queue and presents them to decode over a
//  valid/ready handshake. Accepts branch/jump redirects, which flush the queue and reload the PC.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset; bits [1:0] must be 0
//  QDEPTH     2              fetch queue entries; power of two, >= 2
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   synchronous, active-low reset
//  imem_addr       out  32  byte address to instruction memory; always equals pc_q
//  imem_instr      in   32  instruction word at imem_addr, valid in the same cycle
//  redirect_valid  in   1   redirect request from execute
//  redirect_pc     in   32  redirect target; bits [1:0] ignored (forced 0)
//  if_valid        out  1   queue head holds a valid instruction
//  if_ready        in   1   decode accepts head this cycle
//  if_instr        out  32  head instruction word
//  if_pc           out  32  PC of head instruction
//  fetch_count     out  32  count of words pushed into queue, wraps at 2^32
// BEHAVIOUR
//  Interface rules
//  - Clock and reset: one clock. Reset is synchronous and active-low, sampled on rising clk.
//  - imem_addr = pc_q: purely registered, no combinational path from any input.
//  Reset (rst_n=0 at edge)
//  - pc_q=RESET_PC, queue empty, if_valid=0, fetch_count=0.
//  - if_instr/if_pc hold 32'h0000_0013 (NOP) and 32'h0 while empty.
//  Handshake
//  - pop = if_valid & if_ready. Outputs are stable while if_valid=1 and if_ready=0.
//  - if_valid never drops without a pop or a redirect.
//  Fetch
//  - push = !redirect_valid & (count<QDEPTH | pop).
//  - On push: enqueue {pc_q, imem_instr}, pc_q += 4, fetch_count += 1.
//  - Push and pop in the same cycle are allowed, including when the queue is full.
//  - Count is unchanged in that case.
//  - Latency: first instruction is visible on if_valid the cycle after reset deasserts.
//  - Steady state: throughput 1 instr/cycle when if_ready stays 1.
//  Redirect (highest priority)
//  - redirect_valid=1 at edge: queue flushed to empty, pc_q={redirect_pc[31:2],2'b00}, no push.
//  - A pop in the same cycle still counts as consumed by decode; no further entries survive.
//  - if_valid=0 for exactly one cycle after a redirect.
//  - The target instruction appears on the following cycle with if_pc = target.
//  - Back-to-back redirects: the last one wins. Each flushes.
//  Arithmetic / boundaries
//  - pc_q wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no error.
//  - fetch_count wraps 32'hFFFF_FFFF -> 0.
//  - Full and !pop: no push, PC holds, imem_addr stable.
//  - Empty: if_valid=0, and if_ready is ignored.
//  - Reset asserted mid-stream overrides redirect and handshake, giving the reset state next cycle.
//  States (implicit in queue count)
//  - EMPTY(0) -> PARTIAL -> FULL(QDEPTH).
//  - Redirect: any state -> EMPTY.
//  - Reset: any state -> EMPTY.
// STRUCTURE
//  - riscv_pkg (shared):
//    - XLEN=32
//    - INSTR_NOP=32'h0000_0013
//    - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t
//  - Sub-module fetch_queue #(QDEPTH): synchronous FIFO of fetch_entry_t.
//    - Ports: push, pop, flush (sync), full, empty, head.
//    - flush has priority over push.
//  - Top holds pc_q, fetch_count, push/redirect logic.
// TESTING (memory stub: imem_instr = 32'hA000_0000 | imem_addr)
//  1. Reset, RESET_PC=0, if_ready=1 for 4 cycles.
//     -> if_pc 0,4,8,C on consecutive cycles; if_instr A0000000..A000000C; fetch_count=4.
//  2. if_ready=0 from reset for 5 cycles.
//     -> queue fills with pc 0,4. imem_addr holds 8. if_pc stays 0. fetch_count=2.
//  3. Redirect to 32'h0000_0102 while full.
//     -> next cycle if_valid=0. Then if_pc=0x100, if_instr=A0000100. Old entries never appear.
//  4. pc_q=FFFF_FFF8, if_ready=1.
//     -> if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 on consecutive pops.
//  5. redirect_valid with pop of head pc=0x10.
//     -> 0x10 counted consumed. No entry 0x14 appears. Next valid if_pc = target.
//  6. rst_n=0 mid-stream with queue full.
//     -> next cycle if_valid=0, imem_addr=RESET_PC, fetch_count=0.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RISC-V front-end types and constants.
//               XLEN      - architectural register / address width
//               INSTR_NOP - canonical NOP (addi x0, x0, 0)
//               fetch_entry_t - {pc, instr} pair carried from fetch to decode
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Word-aligns a byte address by clearing the two low bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO of fetch_entry_t with a synchronous flush.
//               Head entry is presented combinationally from storage.
// Ports       : clk, rst_n (sync, active-low)
//               push, wr_data  - enqueue request and entry
//               pop            - dequeue request
//               flush          - empty the queue (beats push and pop)
//               full, empty    - occupancy flags
//               head           - oldest entry (undefined while empty)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t wr_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int c_PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    fetch_entry_t       r_mem [QDEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign full  = (r_count == c_CNT_W'(QDEPTH));
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

    // A push into a full queue is only legal when the head leaves this cycle.
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    // Storage carries no reset: entries are only visible via the count.
    always_ff @(posedge clk) begin
        if (w_push_ok && !flush) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : fetch_queue
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch front end. Holds the PC, drives the
//               instruction memory address, buffers {pc, instr} pairs and
//               presents them to decode over valid/ready. Redirects flush
//               the queue and reload the PC.
// Ports       : clk, rst_n (sync, active-low)
//               imem_addr  out - byte address to instruction memory (= pc)
//               imem_instr in  - instruction word at imem_addr, same cycle
//               redirect_valid/redirect_pc in - redirect from execute
//               if_valid/if_ready/if_instr/if_pc - decode handshake
//               fetch_count out - words pushed into the queue (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] fetch_count
);

    logic [31:0]  r_pc;
    logic [31:0]  r_fetch_count;

    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    fetch_entry_t w_new_entry;
    fetch_entry_t w_head;

    // Address comes straight from the PC register: no input-to-output path.
    assign imem_addr   = r_pc;
    assign fetch_count = r_fetch_count;

    assign w_pop  = ~w_empty & if_ready;
    // Redirect suppresses the fetch of the now-stale word at the old PC.
    assign w_push = ~redirect_valid & (~w_full | w_pop);

    assign w_new_entry.pc    = r_pc;
    assign w_new_entry.instr = imem_instr;

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_push),
        .wr_data (w_new_entry),
        .pop     (w_pop),
        .flush   (redirect_valid),
        .full    (w_full),
        .empty   (w_empty),
        .head    (w_head)
    );

    // Present a NOP at PC 0 while empty so decode never sees stale storage.
    assign if_valid = ~w_empty;
    assign if_instr = w_empty ? INSTR_NOP : w_head.instr;
    assign if_pc    = w_empty ? 32'h0     : w_head.pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= word_align(RESET_PC);
            r_fetch_count <= '0;
        end else if (redirect_valid) begin
            r_pc          <= word_align(redirect_pc);
        end else if (w_push) begin
            r_pc          <= r_pc + 32'd4;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit with a
//               combinational memory stub (instr = 32'hA000_0000 | addr).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] fetch_count;

    int vectors;
    int miscompares;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_count    (fetch_count)
    );

    assign imem_instr = 32'hA000_0000 | imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = ready;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;

        // 1. Reset state, then streaming with if_ready held high.
        do_reset(1'b1);
        check("rst_valid", {31'h0, if_valid}, 32'h0);
        check("rst_pc",    if_pc,       32'h0);
        check("rst_instr", if_instr,    32'h0000_0013);
        check("rst_addr",  imem_addr,   32'h0);
        check("rst_count", fetch_count, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s1_valid", {31'h0, if_valid}, 32'h1);
            check("s1_pc",    if_pc,    32'(i * 4));
            check("s1_instr", if_instr, 32'hA000_0000 | 32'(i * 4));
        end
        check("s1_count", fetch_count, 32'd4);

        // 2. Decode stalled from reset: queue fills with 0,4 and PC holds at 8.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s2_pc_stable", if_pc, 32'h0);
        end
        check("s2_valid", {31'h0, if_valid}, 32'h1);
        check("s2_instr", if_instr,    32'hA000_0000);
        check("s2_addr",  imem_addr,   32'h8);
        check("s2_count", fetch_count, 32'd2);

        // 3. Redirect to an unaligned target while full.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        check("s3_bubble", {31'h0, if_valid}, 32'h0);
        check("s3_addr",   imem_addr, 32'h100);
        tick();
        check("s3_valid", {31'h0, if_valid}, 32'h1);
        check("s3_pc",    if_pc,    32'h100);
        check("s3_instr", if_instr, 32'hA000_0100);
        if_ready = 1'b1;
        tick();
        check("s3_next_pc", if_pc, 32'h104);

        // 4. PC wrap across the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        check("s4_bubble", {31'h0, if_valid}, 32'h0);
        tick();
        check("s4_pc0", if_pc, 32'hFFFF_FFF8);
        tick();
        check("s4_pc1", if_pc, 32'hFFFF_FFFC);
        tick();
        check("s4_pc2",    if_pc,    32'h0000_0000);
        check("s4_instr2", if_instr, 32'hA000_0000);
        check("s4_addr",   imem_addr, 32'h4);

        // 5. Redirect in the same cycle as a pop of head pc=0x10.
        do_reset(1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        check("s5_head",  if_pc,       32'h10);
        check("s5_count", fetch_count, 32'd2);
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check("s5_bubble",      {31'h0, if_valid}, 32'h0);
        check("s5_count_flush", fetch_count, 32'd2);
        tick();
        check("s5_valid",  {31'h0, if_valid}, 32'h1);
        check("s5_target", if_pc,       32'h200);
        check("s5_count2", fetch_count, 32'd3);

        // 6. Reset mid-stream with the queue full, overriding redirect and pop.
        do_reset(1'b0);
        tick();
        tick();
        tick();
        check("s6_full_addr", imem_addr, 32'h8);
        rst_n          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        if_ready       = 1'b1;
        tick();
        check("s6_valid", {31'h0, if_valid}, 32'h0);
        check("s6_addr",  imem_addr,   32'h0);
        check("s6_count", fetch_count, 32'h0);
        check("s6_instr", if_instr,    32'h0000_0013);
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        tick();
        check("s6_restart_pc", if_pc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire
